// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling.
//
// Ports:
//   clk       system clock, rising edge only
//   rstn      synchronous active-low reset
//   rxd       serial line (asynchronous, idle high)
//   rdata     last correctly received byte, held until the next good frame
//   rx_ready  one-cycle pulse when rdata has just been updated
//   ferr      one-cycle pulse when the stop bit is sampled low
//   rx_busy   high whenever the FSM is outside s_idle
//
// state        | meaning
// s_idle       | line idle, waiting for rxd_s low
// s_start_bit  | timing to the middle of the start bit, glitch check
// s_bit_0..7   | one full bit period per data bit, sample at its end (mid-bit)
// s_stop_bit   | sample the stop bit, publish byte or flag framing error
// s_break      | stop bit was low, wait for the line to return high
module uart_rx #(
  parameter int unsigned CLK_PER_HALF_BIT = 5208
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rx_ready,
  output logic       ferr,
  output logic       rx_busy
);

  localparam logic [31:0] HALF_LAST = 32'(CLK_PER_HALF_BIT - 1);
  localparam logic [31:0] FULL_LAST = 32'(2 * CLK_PER_HALF_BIT - 1);

  // Data-bit states are consecutive so "next bit" is state + 1, and
  // s_bit_7 + 1 lands on s_stop_bit.
  typedef enum logic [3:0] {
    s_idle      = 4'd0,
    s_start_bit = 4'd1,
    s_bit_0     = 4'd2,
    s_bit_1     = 4'd3,
    s_bit_2     = 4'd4,
    s_bit_3     = 4'd5,
    s_bit_4     = 4'd6,
    s_bit_5     = 4'd7,
    s_bit_6     = 4'd8,
    s_bit_7     = 4'd9,
    s_stop_bit  = 4'd10,
    s_break     = 4'd11
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rx_ready_q, rx_ready_d;
  logic        ferr_q, ferr_d;
  logic        rxd_meta_q, rxd_meta_d;
  logic        rxd_s_q, rxd_s_d;

  always_comb begin
    rxd_meta_d = rxd;
    rxd_s_d    = rxd_meta_q;
    state_d    = state_q;
    cnt_d      = cnt_q + 32'd1;
    shreg_d    = shreg_q;
    rdata_d    = rdata_q;
    rx_ready_d = 1'b0;
    ferr_d     = 1'b0;

    unique case (state_q)
      s_idle: begin
        if (!rxd_s_q) begin
          state_d = s_start_bit;
          cnt_d   = '0;
        end
      end
      s_start_bit: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          // A high line at mid start bit was only a glitch.
          state_d = rxd_s_q ? s_idle : s_bit_0;
        end
      end
      s_bit_0, s_bit_1, s_bit_2, s_bit_3,
      s_bit_4, s_bit_5, s_bit_6, s_bit_7: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shreg_d = {rxd_s_q, shreg_q[7:1]};
          state_d = state_t'(state_q + 4'd1);
        end
      end
      s_stop_bit: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            rdata_d    = shreg_q;
            rx_ready_d = 1'b1;
            state_d    = s_idle;
          end else begin
            ferr_d  = 1'b1;
            state_d = s_break;
          end
        end
      end
      s_break: begin
        if (rxd_s_q) begin
          cnt_d   = '0;
          state_d = s_idle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = s_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= s_idle;
      cnt_q      <= '0;
      shreg_q    <= '0;
      rdata_q    <= 8'h00;
      rx_ready_q <= 1'b0;
      ferr_q     <= 1'b0;
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      rdata_q    <= rdata_d;
      rx_ready_q <= rx_ready_d;
      ferr_q     <= ferr_d;
      rxd_meta_q <= rxd_meta_d;
      rxd_s_q    <= rxd_s_d;
    end
  end

  assign rdata    = rdata_q;
  assign rx_ready = rx_ready_q;
  assign ferr     = ferr_q;
  assign rx_busy  = (state_q != s_idle);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx with CLK_PER_HALF_BIT = 4 (8-cycle bit period).
// The line waveform is recorded per cycle; a receiver model working on
// absolute sample indices predicts every output each cycle.
module tb_uart_rx;

  localparam int H    = 4;
  localparam int BIT  = 2 * H;
  localparam int HMAX = 4096;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rxd  = 1'b1;
  logic [7:0] rdata;
  logic       rx_ready;
  logic       ferr;
  logic       rx_busy;

  uart_rx #(.CLK_PER_HALF_BIT(H)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rxd      (rxd),
    .rdata    (rdata),
    .rx_ready (rx_ready),
    .ferr     (ferr),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= ~rstn;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Line history: hist[c] is the rxd value driven during cycle c.
  bit hist [0:HMAX-1];

  typedef enum {M_IDLE, M_FRAME, M_BREAK} mmode_t;
  mmode_t     m_mode  = M_IDLE;
  int         m_e     = 0;
  logic [7:0] m_rdata = 8'h00;
  logic       exp_ready, exp_ferr, exp_busy;
  int         cnt_ready = 0;
  int         cnt_ferr  = 0;
  int         last_ready_cyc = 0;

  // The receiver acts on line index i three cycles later (two sync stages
  // plus the FSM register), so the model consumes hist[cyc-3] each cycle.
  always @(negedge clk) begin
    int i;
    logic [7:0] b;
    if (cyc < HMAX) hist[cyc] = rxd;
    exp_ready = 1'b0;
    exp_ferr  = 1'b0;
    if (rst_seen) begin
      m_mode  = M_IDLE;
      m_rdata = 8'h00;
      if (cyc >= 1) hist[cyc-1] = 1'b1;
      if (cyc >= 2) hist[cyc-2] = 1'b1;
    end else begin
      i = cyc - 3;
      if (i >= 0) begin
        case (m_mode)
          M_IDLE:  if (hist[i] == 1'b0) begin m_mode = M_FRAME; m_e = i; end
          M_FRAME: begin
            if (i == m_e + H && hist[i]) m_mode = M_IDLE;
            else if (i == m_e + 19*H) begin
              for (int k = 0; k < 8; k++) b[k] = hist[m_e + H + 2*H*(k+1)];
              if (hist[i]) begin
                exp_ready = 1'b1;
                m_rdata   = b;
                m_mode    = M_IDLE;
              end else begin
                exp_ferr = 1'b1;
                m_mode   = M_BREAK;
              end
            end
          end
          M_BREAK: if (hist[i]) m_mode = M_IDLE;
          default: m_mode = M_IDLE;
        endcase
      end
    end
    exp_busy = (m_mode != M_IDLE);
    check("rx_ready", rx_ready, exp_ready);
    check("ferr",     ferr,     exp_ferr);
    check("rdata",    rdata,    m_rdata);
    check("rx_busy",  rx_busy,  exp_busy);
    if (rx_ready) begin cnt_ready++; last_ready_cyc = cyc; end
    if (ferr) cnt_ferr++;
  end

  task automatic drive(input logic v, input int n);
    rxd = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // permille scales the transmitter bit period; stop_low > 0 holds the
  // stop bit low for that many nominal bit periods.
  task automatic send(input logic [7:0] d, input int permille, input int stop_low, output int e);
    int b0, b1;
    logic v;
    e = cyc;
    for (int k = 0; k < 10; k++) begin
      b0 = (k * BIT * permille + 500) / 1000;
      b1 = ((k + 1) * BIT * permille + 500) / 1000;
      v  = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
      if (k == 9 && stop_low > 0) drive(1'b0, stop_low * BIT);
      else drive(v, b1 - b0);
    end
  endtask

  initial begin
    int e, r0, f0;
    rstn = 1'b0;
    drive(1'b1, 4);
    check("reset_rdata", rdata, 8'h00);
    check("reset_ready", rx_ready, 1'b0);
    check("reset_ferr",  ferr, 1'b0);
    check("reset_busy",  rx_busy, 1'b0);
    rstn = 1'b1;
    drive(1'b1, 4);

    // single frame A5, latency 19*H+3 = 79 cycles
    r0 = cnt_ready; f0 = cnt_ferr;
    send(8'hA5, 1000, 0, e);
    drive(1'b1, 4);
    check("a5_pulses",  cnt_ready - r0, 1);
    check("a5_rdata",   rdata, 8'hA5);
    check("a5_model",   m_rdata, 8'hA5);
    check("a5_latency", last_ready_cyc - e, 79);
    check("a5_ferr",    cnt_ferr - f0, 0);

    // back-to-back 00 then FF, single stop bit
    r0 = cnt_ready;
    send(8'h00, 1000, 0, e);
    check("b2b_first", rdata, 8'h00);
    send(8'hFF, 1000, 0, e);
    drive(1'b1, 4);
    check("b2b_pulses", cnt_ready - r0, 2);
    check("b2b_second", rdata, 8'hFF);

    // 2-cycle glitch
    r0 = cnt_ready; f0 = cnt_ferr;
    drive(1'b0, 2);
    drive(1'b1, 12);
    check("glitch_ready", cnt_ready - r0, 0);
    check("glitch_ferr",  cnt_ferr - f0, 0);
    check("glitch_busy",  rx_busy, 1'b0);

    // 3C with stop held low for 3 bit periods, then 81
    r0 = cnt_ready; f0 = cnt_ferr;
    send(8'h3C, 1000, 3, e);
    check("brk_busy",  rx_busy, 1'b1);
    check("brk_ferr",  cnt_ferr - f0, 1);
    check("brk_rdata", rdata, 8'hFF);
    check("brk_ready", cnt_ready - r0, 0);
    drive(1'b1, 8);
    check("brk_idle",  rx_busy, 1'b0);
    send(8'h81, 1000, 0, e);
    drive(1'b1, 4);
    check("after_brk_rdata", rdata, 8'h81);
    check("after_brk_pulse", cnt_ready - r0, 1);

    // reset during s_bit_3 of 55, then 96
    r0 = cnt_ready; f0 = cnt_ferr;
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b0, BIT);
    drive(1'b1, BIT);
    drive(1'b0, 4);
    check("mid_busy", rx_busy, 1'b1);
    rstn = 1'b0;
    drive(1'b1, 3);
    check("rst_rdata", rdata, 8'h00);
    check("rst_ready", rx_ready, 1'b0);
    check("rst_ferr",  ferr, 1'b0);
    check("rst_busy",  rx_busy, 1'b0);
    rstn = 1'b1;
    drive(1'b1, 6);
    check("rst_no_pulse", (cnt_ready - r0) + (cnt_ferr - f0), 0);
    send(8'h96, 1000, 0, e);
    drive(1'b1, 4);
    check("post_rst_rdata", rdata, 8'h96);

    // transmitter +3% and -3% bit period
    r0 = cnt_ready;
    send(8'hC3, 1030, 0, e);
    drive(1'b1, 6);
    check("slow_rdata",  rdata, 8'hC3);
    check("slow_pulses", cnt_ready - r0, 1);
    drive(1'b1, 8);
    r0 = cnt_ready;
    send(8'h5A, 1000, 0, e);
    send(8'hC3, 970, 0, e);
    drive(1'b1, 6);
    check("fast_rdata",  rdata, 8'hC3);
    check("fast_pulses", cnt_ready - r0, 2);
    check("total_ferr",  cnt_ferr, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
